// File: rtl/alu_multiciclo.sv
// alu_multiciclo: multi-cycle ALU with valid/ready handshakes on both sides.
//
// Parameter:
//   ANCHO       operand/result width in bits (power of two, 8..64)
// Ports:
//   CLK         clock, all state updates on the rising edge
//   RST         synchronous active-high reset
//   VALIDO_ENT  request valid        LISTO_ENT   block can accept a request
//   OPERADOR1/2 operands             SEL         operation code
//   VALIDO_SAL  result valid         LISTO_SAL   consumer accepts the result
//   RESULTADO   registered result    CERO/ACARREO/DESBORDE registered flags
//
// Build option:
//   ALU_MULT_EN  when defined, SEL=101 runs a radix-2 shift-add multiplier
//                (one bit per cycle). When undefined, SEL=101 returns 0 in
//                one cycle and the FSM has no MULT state.
module alu_multiciclo #(
  parameter int unsigned ANCHO = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VALIDO_ENT,
  output logic             LISTO_ENT,
  input  logic [ANCHO-1:0] OPERADOR1,
  input  logic [ANCHO-1:0] OPERADOR2,
  input  logic [2:0]       SEL,
  output logic             VALIDO_SAL,
  input  logic             LISTO_SAL,
  output logic [ANCHO-1:0] RESULTADO,
  output logic             CERO,
  output logic             ACARREO,
  output logic             DESBORDE
);

  localparam int unsigned LOG = $clog2(ANCHO);
  localparam int unsigned MSB = ANCHO - 1;

  localparam logic [1:0] LIBRE   = 2'd0;
`ifdef ALU_MULT_EN
  localparam logic [1:0] MULT    = 2'd1;
`endif
  localparam logic [1:0] ENTREGA = 2'd2;

  logic [1:0]       r_estado;
  logic [ANCHO-1:0] r_resultado;
  logic             r_cero;
  logic             r_acarreo;
  logic             r_desborde;

  logic             w_acepta;
  logic [ANCHO:0]   w_suma;
  logic [ANCHO-1:0] w_dif;
  logic [ANCHO-1:0] w_res;
  logic             w_acarreo;
  logic             w_desborde;

  // Ready while idle, or while holding a result that is being consumed this
  // edge, so single-cycle ops can stream one per clock.
  assign LISTO_ENT  = (r_estado == LIBRE) || ((r_estado == ENTREGA) && LISTO_SAL);
  assign w_acepta   = VALIDO_ENT && LISTO_ENT;
  assign VALIDO_SAL = (r_estado == ENTREGA);
  assign RESULTADO  = r_resultado;
  assign CERO       = r_cero;
  assign ACARREO    = r_acarreo;
  assign DESBORDE   = r_desborde;

  // Single-cycle datapath, evaluated on the live request inputs.
  always_comb begin
    w_suma     = {1'b0, OPERADOR1} + {1'b0, OPERADOR2};
    w_dif      = OPERADOR1 - OPERADOR2;
    w_res      = '0;
    w_acarreo  = 1'b0;
    w_desborde = 1'b0;
    case (SEL)
      3'b000: w_res = OPERADOR1 & OPERADOR2;
      3'b001: w_res = OPERADOR1 | OPERADOR2;
      3'b010: begin
        w_res      = w_suma[ANCHO-1:0];
        w_acarreo  = w_suma[ANCHO];
        // Same-sign operands giving a different-sign sum.
        w_desborde = (OPERADOR1[MSB] == OPERADOR2[MSB]) && (w_suma[MSB] != OPERADOR1[MSB]);
      end
      3'b110: begin
        w_res      = w_dif;
        w_acarreo  = (OPERADOR1 < OPERADOR2);
        // Opposite-sign operands with the difference taking the subtrahend's sign.
        w_desborde = (OPERADOR1[MSB] != OPERADOR2[MSB]) && (w_dif[MSB] != OPERADOR1[MSB]);
      end
      3'b111: w_res = {{(ANCHO-1){1'b0}}, (OPERADOR1 < OPERADOR2)};
      3'b100: w_res = ~(OPERADOR1 | OPERADOR2);
      3'b011: w_res = OPERADOR1 << OPERADOR2[LOG-1:0];
      default: w_res = '0;
    endcase
  end

`ifdef ALU_MULT_EN
  // Accumulator holds {partial product, remaining multiplier bits}; each step
  // conditionally adds the multiplicand to the top half and shifts right.
  logic [2*ANCHO-1:0] r_acum;
  logic [ANCHO-1:0]   r_mcand;
  logic [LOG-1:0]     r_cuenta;
  logic [ANCHO:0]     w_parcial;
  logic [2*ANCHO-1:0] w_acum_sig;

  always_comb begin
    w_parcial  = {1'b0, r_acum[2*ANCHO-1:ANCHO]} + (r_acum[0] ? {1'b0, r_mcand} : '0);
    w_acum_sig = {w_parcial, r_acum[ANCHO-1:1]};
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_estado    <= LIBRE;
      r_resultado <= '0;
      r_cero      <= 1'b0;
      r_acarreo   <= 1'b0;
      r_desborde  <= 1'b0;
`ifdef ALU_MULT_EN
      r_acum      <= '0;
      r_mcand     <= '0;
      r_cuenta    <= '0;
`endif
    end else if (w_acepta) begin
`ifdef ALU_MULT_EN
      if (SEL == 3'b101) begin
        r_estado <= MULT;
        r_acum   <= {{ANCHO{1'b0}}, OPERADOR2};
        r_mcand  <= OPERADOR1;
        r_cuenta <= '0;
      end else
`endif
      begin
        r_estado    <= ENTREGA;
        r_resultado <= w_res;
        r_cero      <= (w_res == '0);
        r_acarreo   <= w_acarreo;
        r_desborde  <= w_desborde;
      end
    end else if ((r_estado == ENTREGA) && LISTO_SAL) begin
      r_estado <= LIBRE;
    end
`ifdef ALU_MULT_EN
    else if (r_estado == MULT) begin
      r_acum   <= w_acum_sig;
      r_cuenta <= r_cuenta + 1'b1;
      if (r_cuenta == LOG'(ANCHO - 1)) begin
        r_estado    <= ENTREGA;
        r_resultado <= w_acum_sig[ANCHO-1:0];
        r_cero      <= (w_acum_sig[ANCHO-1:0] == '0);
        r_acarreo   <= |w_acum_sig[2*ANCHO-1:ANCHO];
        r_desborde  <= 1'b0;
      end
    end
`endif
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo (ANCHO=32). Expected results come
// from a behavioural model and are queued when a request is accepted; the
// output monitor pops and compares on every consumed result.
module tb_alu_multiciclo;

  localparam int unsigned W = 32;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSll = 3'b011;
  localparam logic [2:0] OpNor = 3'b100;
  localparam logic [2:0] OpMul = 3'b101;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  localparam longint MaxS = 64'sd2147483647;
  localparam longint MinS = -64'sd2147483648;

`ifdef ALU_MULT_EN
  localparam int unsigned MulLat = W + 1;
`else
  localparam int unsigned MulLat = 1;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST;
  logic         VALIDO_ENT;
  logic         LISTO_ENT;
  logic [W-1:0] OPERADOR1;
  logic [W-1:0] OPERADOR2;
  logic [2:0]   SEL;
  logic         VALIDO_SAL;
  logic         LISTO_SAL;
  logic [W-1:0] RESULTADO;
  logic         CERO;
  logic         ACARREO;
  logic         DESBORDE;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_recv   = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  bit          rand_ready = 1'b0;

  alu_multiciclo #(.ANCHO(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .VALIDO_ENT (VALIDO_ENT),
    .LISTO_ENT  (LISTO_ENT),
    .OPERADOR1  (OPERADOR1),
    .OPERADOR2  (OPERADOR2),
    .SEL        (SEL),
    .VALIDO_SAL (VALIDO_SAL),
    .LISTO_SAL  (LISTO_SAL),
    .RESULTADO  (RESULTADO),
    .CERO       (CERO),
    .ACARREO    (ACARREO),
    .DESBORDE   (DESBORDE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [2:0] sel, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      t;
    logic [W:0]  w;
    logic [63:0] p;
    logic [4:0]  sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[4:0];
    e  = '0;
    case (sel)
      OpAnd: e.res = a & b;
      OpOr:  e.res = a | b;
      OpAdd: begin
        w     = {1'b0, a} + {1'b0, b};
        e.res = w[W-1:0];
        e.c   = w[W];
        t     = sa + sb;
        e.v   = (t > MaxS) || (t < MinS);
      end
      OpSub: begin
        e.res = a - b;
        e.c   = (a < b);
        t     = sa - sb;
        e.v   = (t > MaxS) || (t < MinS);
      end
      OpSlt: e.res = (a < b) ? 32'd1 : 32'd0;
      OpNor: e.res = ~(a | b);
      OpSll: e.res = a << sh;
      default: begin
`ifdef ALU_MULT_EN
        p     = {32'd0, a} * {32'd0, b};
        e.res = p[W-1:0];
        e.c   = (p[63:32] != 32'd0);
`else
        p     = 64'd0;
        e.res = '0;
`endif
      end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Holds the request until it is accepted; returns just after the accepting edge.
  task automatic send(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    VALIDO_ENT = 1'b1;
    SEL        = sel;
    OPERADOR1  = a;
    OPERADOR2  = b;
    n          = 0;
    @(negedge CLK);
    while (!LISTO_ENT && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!LISTO_ENT) check_eq("accept_timeout", 64'd0, 64'd1);
    else sb_q.push_back(model(sel, a, b));
    step();
  endtask

  always @(negedge CLK) begin
    if (!RST && VALIDO_SAL && LISTO_SAL) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_result", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("resultado", RESULTADO, mon_e.res);
        check_eq("cero", CERO, mon_e.z);
        check_eq("acarreo", ACARREO, mon_e.c);
        check_eq("desborde", DESBORDE, mon_e.v);
        n_recv++;
      end
    end
  end

  always @(posedge CLK) begin
    #2;
    if (rand_ready) LISTO_SAL = 1'($urandom_range(0, 1));
  end

  initial begin
    int unsigned lat;
    bit          listo_bad;
    int unsigned base;
    longint      t0;
    int          n;
    logic [2:0]  s;
    logic [W-1:0] a;
    logic [W-1:0] b;

    RST = 1'b1; VALIDO_ENT = 1'b0; LISTO_SAL = 1'b1;
    SEL = 3'b000; OPERADOR1 = '0; OPERADOR2 = '0;
    repeat (3) step();
    RST = 1'b0;
    @(negedge CLK);
    check_eq("rst_valido_sal", VALIDO_SAL, 0);
    check_eq("rst_listo_ent", LISTO_ENT, 1);
    check_eq("rst_resultado", RESULTADO, 0);
    check_eq("rst_cero", CERO, 0);
    check_eq("rst_acarreo", ACARREO, 0);
    check_eq("rst_desborde", DESBORDE, 0);
    step();

    // ADD wrap-around with carry out.
    send(OpAdd, 32'hFFFF_FFFF, 32'h0000_0001);
    VALIDO_ENT = 1'b0;
    @(negedge CLK);
    check_eq("add_valid_1edge", VALIDO_SAL, 1);
    check_eq("add_res", RESULTADO, 0);
    check_eq("add_cero", CERO, 1);
    check_eq("add_acarreo", ACARREO, 1);
    check_eq("add_desborde", DESBORDE, 0);
    step();

    send(OpSub, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    VALIDO_ENT = 1'b0;
    @(negedge CLK);
    check_eq("sub_res", RESULTADO, 32'h8000_0000);
    check_eq("sub_desborde", DESBORDE, 1);
    check_eq("sub_acarreo", ACARREO, 1);
    step();

    send(OpSlt, 32'd3, 32'd5);
    VALIDO_ENT = 1'b0;
    @(negedge CLK);
    check_eq("slt_res", RESULTADO, 1);
    step();

    // SLL held under back-pressure; a competing request must be ignored.
    LISTO_SAL = 1'b0;
    send(OpSll, 32'h1, 32'h25);
    VALIDO_ENT = 1'b1; SEL = OpAdd; OPERADOR1 = 32'h1234; OPERADOR2 = 32'h5678;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check_eq("sll_stall_valido", VALIDO_SAL, 1);
      check_eq("sll_stall_res", RESULTADO, 32'h20);
      check_eq("sll_stall_listo_ent", LISTO_ENT, 0);
      step();
    end
    VALIDO_ENT = 1'b0;
    LISTO_SAL  = 1'b1;
    @(negedge CLK);
    check_eq("sll_release_listo_ent", LISTO_ENT, 1);
    step();

    // Back-to-back single-cycle ops: one accepted and one delivered per clock.
    base = n_recv;
    t0   = $time;
    send(OpAnd, 32'hF0F0_1234, 32'h0FF0_FF00);
    send(OpOr,  32'hF000_0001, 32'h0000_0F10);
    send(OpNor, 32'h0F0F_0F0F, 32'h0000_F0F0);
    VALIDO_ENT = 1'b0;
    check_eq("b2b_cycles", ($time - t0) / 10, 3);
    repeat (2) step();
    check_eq("b2b_count", n_recv - base, 3);

    // Multiply latency and handshake gating.
    send(OpMul, 32'h0001_0000, 32'h0001_0000);
    VALIDO_ENT = 1'b0;
    lat = 1;
    listo_bad = 1'b0;
    @(negedge CLK);
    while (!VALIDO_SAL && lat < 200) begin
      if (LISTO_ENT) listo_bad = 1'b1;
      step();
      @(negedge CLK);
      lat++;
    end
    check_eq("mul_latency", lat, MulLat);
    check_eq("mul_listo_ent_busy", listo_bad, 0);
    check_eq("mul_res", RESULTADO, 0);
    check_eq("mul_cero", CERO, 1);
`ifdef ALU_MULT_EN
    check_eq("mul_acarreo", ACARREO, 1);
`else
    check_eq("mul_acarreo", ACARREO, 0);
`endif
    step();

    // Reset part-way through an operation discards it.
    LISTO_SAL = 1'b0;
    send(OpMul, 32'hDEAD_BEEF, 32'h1234_5677);
    VALIDO_ENT = 1'b0;
    repeat (10) step();
    RST = 1'b1;
    sb_q.delete();
    step();
    RST = 1'b0;
    @(negedge CLK);
    check_eq("rstmid_valido_sal", VALIDO_SAL, 0);
    check_eq("rstmid_resultado", RESULTADO, 0);
    check_eq("rstmid_listo_ent", LISTO_ENT, 1);
    step();
    LISTO_SAL = 1'b1;
    send(OpAdd, 32'd2, 32'd2);
    VALIDO_ENT = 1'b0;
    @(negedge CLK);
    check_eq("rstmid_add", RESULTADO, 32'd4);
    step();

    // Random traffic with random consumer back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      s = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) b = a;
      if (i % 7 == 0) a = 32'h8000_0000;
      send(s, a, b);
    end
    VALIDO_ENT = 1'b0;
    rand_ready = 1'b0;
    LISTO_SAL  = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check_eq("drain_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_multiciclo.md
ALU_MULTICICLO -- requirements
Module: alu_multiciclo

Interface
REQ-001 SHALL have parameter: ANCHO, 32, operand/result width in bits (power of two, 8..64).
REQ-002 SHALL have ports: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have ports: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: VALIDO_ENT  input  1  request valid.
REQ-005 SHALL have ports: LISTO_ENT  output  1  block can accept a request this cycle.
REQ-006 SHALL have ports: OPERADOR1, OPERADOR2  input  ANCHO each  operands.
REQ-007 SHALL have ports: SEL  input  3  operation code.
REQ-008 SHALL have ports: VALIDO_SAL  output  1  result valid.
REQ-009 SHALL have ports: LISTO_SAL  input  1  consumer accepts result.
REQ-010 SHALL have ports: RESULTADO  output  ANCHO  registered result.
REQ-011 SHALL have ports: CERO, ACARREO, DESBORDE  output  1 each  registered flags.

Function
REQ-012 SHALL accept a request on a rising edge where VALIDO_ENT and LISTO_ENT are both high; OPERADOR1, OPERADOR2 and SEL are captured then and ignored afterwards.
REQ-013 SHALL decode SEL: 000 AND; 001 OR; 010 ADD; 110 SUB; 111 unsigned set-less-than (1 if OPERADOR1<OPERADOR2, else 0); 100 NOR; 011 logical shift left of OPERADOR1 by OPERADOR2[log2(ANCHO)-1:0]; 101 multiply (low ANCHO bits of the product); any other code gives result 0.
REQ-014 SHALL be a three-state FSM: LIBRE (idle), MULT (iterating), ENTREGA (result held).
REQ-015 SHALL move LIBRE->ENTREGA on acceptance of any non-multiply op; RESULTADO and flags are valid after exactly 1 edge.
REQ-016 SHALL move LIBRE->MULT on acceptance of SEL=101 and perform radix-2 shift-add over a 2*ANCHO accumulator, one bit per cycle, entering ENTREGA so VALIDO_SAL rises exactly ANCHO+1 edges after acceptance.
REQ-017 SHALL assert VALIDO_SAL only in ENTREGA; RESULTADO and flags SHALL be stable while VALIDO_SAL=1 and LISTO_SAL=0 (stall of any length).
REQ-018 SHALL leave ENTREGA on an edge with LISTO_SAL=1: to LIBRE, or directly to a new operation if a request is accepted on the same edge.
REQ-019 SHALL drive LISTO_ENT = (state==LIBRE) or (state==ENTREGA and LISTO_SAL), giving one accepted request per cycle for back-to-back non-multiply ops; LISTO_ENT SHALL be 0 in MULT.
REQ-020 SHALL set CERO = (RESULTADO==0) for every operation.
REQ-021 SHALL set ACARREO: ADD carry-out of bit ANCHO-1; SUB 1 when OPERADOR1<OPERADOR2 unsigned (borrow); multiply 1 when the product's upper ANCHO bits are nonzero; 0 otherwise.
REQ-022 SHALL set DESBORDE to two's-complement overflow for ADD and SUB; 0 for all other ops.
REQ-023 SHALL wrap ADD/SUB results modulo 2^ANCHO; a shift amount of 0 returns OPERADOR1 unchanged.
REQ-024 SHALL ignore VALIDO_ENT while LISTO_ENT=0 (no queuing, no loss of the in-flight operation).

Reset
REQ-025 SHALL, on an edge with RST=1, force state LIBRE, clear the accumulator and iteration counter, and drive RESULTADO=0, CERO=0, ACARREO=0, DESBORDE=0, VALIDO_SAL=0.
REQ-026 SHALL give RST priority over acceptance and over any in-progress multiply or held result, which are discarded; LISTO_ENT SHALL be 1 in the cycle after reset.

Configuration
REQ-027 SHALL compile the multiplier and MULT state only when macro ALU_MULT_EN is defined.
REQ-028 SHALL, without ALU_MULT_EN, treat SEL=101 as an unsupported code: result 0, CERO=1, other flags 0, latency 1 edge; the FSM has no MULT state.

Verification
REQ-029 SHALL cover: ADD 0xFFFFFFFF+0x00000001, LISTO_SAL=1 -> after 1 edge RESULTADO=0, CERO=1, ACARREO=1, DESBORDE=0.
REQ-030 SHALL cover: SUB 0x7FFFFFFF-0xFFFFFFFF -> RESULTADO=0x80000000, DESBORDE=1, ACARREO=1; SLT 3,5 -> RESULTADO=1.
REQ-031 SHALL cover (ALU_MULT_EN): MUL 0x00010000*0x00010000 -> VALIDO_SAL at edge 33, RESULTADO=0, CERO=1, ACARREO=1; LISTO_ENT=0 for edges 1..32.
REQ-032 SHALL cover: SLL 0x1 by 0x25 (amount 5) with LISTO_SAL=0 for 4 cycles -> RESULTADO=0x20 held stable, LISTO_ENT=0 until LISTO_SAL=1.
REQ-033 SHALL cover: back-to-back AND/OR/NOR requests with LISTO_SAL=1 -> one result per cycle, no loss or duplication.
REQ-034 SHALL cover: RST=1 at iteration 10 of a multiply -> next cycle VALIDO_SAL=0, RESULTADO=0, LISTO_ENT=1, a following ADD 2+2 returns 4.
